// File: rtl/ex_stage_if.sv
// ============================================================================
// ex_stage_if : ID/EX-side operands and controls plus EX/MEM-side results
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ex_stage_if #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_OP   = 6,
  parameter int ALU_OP  = 4
);
  logic               i_alu_src_CU;
  logic               i_reg_dst_CU;
  logic               i_jal_sel_CU;
  logic [ALU_OP-1:0]  i_alu_op_CU;
  logic [NB_REG-1:0]  i_rs_data;
  logic [NB_REG-1:0]  i_rt_data;
  logic [NB_ADDR-1:0] i_rd_from_ID;
  logic [NB_ADDR-1:0] i_rt_from_ID;
  logic [NB_REG-1:0]  i_inst_sign_extended;
  logic [NB_REG-1:0]  i_aluResult_MEM;
  logic [NB_REG-1:0]  i_aluResult_WB;
  logic [NB_OP-1:0]   i_op_r_tipe;
  logic [1:0]         i_forwardA;
  logic [1:0]         i_forwardB;
  logic [NB_REG-1:0]  o_alu_result;
  logic [NB_ADDR-1:0] o_write_reg;
  logic [NB_ADDR-1:0] o_rd_to_WB;
  logic               o_alu_condition_zero;

  modport master (
    output i_alu_src_CU, i_reg_dst_CU, i_jal_sel_CU, i_alu_op_CU,
    output i_rs_data, i_rt_data, i_rd_from_ID, i_rt_from_ID,
    output i_inst_sign_extended, i_aluResult_MEM, i_aluResult_WB,
    output i_op_r_tipe, i_forwardA, i_forwardB,
    input  o_alu_result, o_write_reg, o_rd_to_WB, o_alu_condition_zero
  );

  modport slave (
    input  i_alu_src_CU, i_reg_dst_CU, i_jal_sel_CU, i_alu_op_CU,
    input  i_rs_data, i_rt_data, i_rd_from_ID, i_rt_from_ID,
    input  i_inst_sign_extended, i_aluResult_MEM, i_aluResult_WB,
    input  i_op_r_tipe, i_forwardA, i_forwardB,
    output o_alu_result, o_write_reg, o_rd_to_WB, o_alu_condition_zero
  );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : MIPS execute stage (forwarding, ALU, dest select) + EX/MEM reg
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_stage #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_OP   = 6,
  parameter int ALU_OP  = 4
) (
  input  wire        i_clk,
  input  wire        i_rst_n,
  ex_stage_if.slave  bus
);

  localparam logic [ALU_OP-1:0]  c_op_add  = 4'b0000;
  localparam logic [ALU_OP-1:0]  c_op_sub  = 4'b0001;
  localparam logic [ALU_OP-1:0]  c_op_rtyp = 4'b0010;
  localparam logic [ALU_OP-1:0]  c_op_and  = 4'b0011;
  localparam logic [ALU_OP-1:0]  c_op_or   = 4'b0100;
  localparam logic [ALU_OP-1:0]  c_op_xor  = 4'b0101;
  localparam logic [ALU_OP-1:0]  c_op_lui  = 4'b0110;
  localparam logic [ALU_OP-1:0]  c_op_slt  = 4'b0111;
  localparam logic [ALU_OP-1:0]  c_op_sltu = 4'b1000;
  localparam logic [NB_ADDR-1:0] c_ra      = 5'd31;

  logic [NB_REG-1:0]  w_op_a;
  logic [NB_REG-1:0]  w_fwd_b;
  logic [NB_REG-1:0]  w_op_b;
  logic [4:0]         w_shamt;
  logic [4:0]         w_shvar;
  logic [NB_REG-1:0]  w_result;
  logic [NB_ADDR-1:0] w_write_reg;
  logic               w_lt_s;
  logic               w_lt_u;

  logic [NB_REG-1:0]  r_alu_result;
  logic [NB_ADDR-1:0] r_write_reg;
  logic [NB_ADDR-1:0] r_rd_to_wb;
  logic               r_zero;

  always_comb begin
    w_op_a = bus.i_rs_data;
    case (bus.i_forwardA)
      2'b01:   w_op_a = bus.i_aluResult_MEM;
      2'b10:   w_op_a = bus.i_aluResult_WB;
      default: w_op_a = bus.i_rs_data;
    endcase

    w_fwd_b = bus.i_rt_data;
    case (bus.i_forwardB)
      2'b01:   w_fwd_b = bus.i_aluResult_MEM;
      2'b10:   w_fwd_b = bus.i_aluResult_WB;
      default: w_fwd_b = bus.i_rt_data;
    endcase
  end

  // The immediate path wins over any forwarding select on B.
  assign w_op_b  = bus.i_alu_src_CU ? bus.i_inst_sign_extended : w_fwd_b;
  assign w_shamt = bus.i_inst_sign_extended[10:6];
  assign w_shvar = w_op_a[4:0];
  assign w_lt_s  = $signed(w_op_a) < $signed(w_op_b);
  assign w_lt_u  = w_op_a < w_op_b;

  always_comb begin
    w_result = w_op_a + w_op_b;
    case (bus.i_alu_op_CU)
      c_op_add:  w_result = w_op_a + w_op_b;
      c_op_sub:  w_result = w_op_a - w_op_b;
      c_op_and:  w_result = w_op_a & w_op_b;
      c_op_or:   w_result = w_op_a | w_op_b;
      c_op_xor:  w_result = w_op_a ^ w_op_b;
      c_op_lui:  w_result = w_op_b << 16;
      c_op_slt:  w_result = {{(NB_REG-1){1'b0}}, w_lt_s};
      c_op_sltu: w_result = {{(NB_REG-1){1'b0}}, w_lt_u};
      c_op_rtyp: begin
        case (bus.i_op_r_tipe)
          6'b100010, 6'b100011: w_result = w_op_a - w_op_b;
          6'b100100: w_result = w_op_a & w_op_b;
          6'b100101: w_result = w_op_a | w_op_b;
          6'b100110: w_result = w_op_a ^ w_op_b;
          6'b100111: w_result = ~(w_op_a | w_op_b);
          6'b101010: w_result = {{(NB_REG-1){1'b0}}, w_lt_s};
          6'b101011: w_result = {{(NB_REG-1){1'b0}}, w_lt_u};
          6'b000000: w_result = w_op_b << w_shamt;
          6'b000010: w_result = w_op_b >> w_shamt;
          6'b000011: w_result = $unsigned($signed(w_op_b) >>> w_shamt);
          6'b000100: w_result = w_op_b << w_shvar;
          6'b000110: w_result = w_op_b >> w_shvar;
          6'b000111: w_result = $unsigned($signed(w_op_b) >>> w_shvar);
          default:   w_result = w_op_a + w_op_b;
        endcase
      end
      default:   w_result = w_op_a + w_op_b;
    endcase
  end

  always_comb begin
    w_write_reg = bus.i_rt_from_ID;
    if (bus.i_jal_sel_CU)
      w_write_reg = c_ra;
    else if (bus.i_reg_dst_CU)
      w_write_reg = bus.i_rd_from_ID;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_rd_to_wb   <= '0;
      r_zero       <= 1'b0;
    end else begin
      r_alu_result <= w_result;
      r_write_reg  <= w_write_reg;
      r_rd_to_wb   <= bus.i_rd_from_ID;
      r_zero       <= (w_result == '0);
    end
  end

  assign bus.o_alu_result         = r_alu_result;
  assign bus.o_write_reg          = r_write_reg;
  assign bus.o_rd_to_WB           = r_rd_to_wb;
  assign bus.o_alu_condition_zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : directed vectors for ex_stage with hand-computed expectations
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;

  logic i_clk;
  logic i_rst_n;
  int   errors;
  int   checks;

  ex_stage_if #(.NB_REG(32), .NB_ADDR(5), .NB_OP(6), .ALU_OP(4)) bus ();

  ex_stage #(.NB_REG(32), .NB_ADDR(5), .NB_OP(6), .ALU_OP(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] res, input logic [4:0] wr,
                           input logic [4:0] rd, input logic zero);
    check({tag, ".result"}, bus.o_alu_result, res);
    check({tag, ".write_reg"}, {27'd0, bus.o_write_reg}, {27'd0, wr});
    check({tag, ".rd_to_WB"}, {27'd0, bus.o_rd_to_WB}, {27'd0, rd});
    check({tag, ".zero"}, {31'd0, bus.o_alu_condition_zero}, {31'd0, zero});
  endtask

  task automatic set_rr(input logic [3:0] op, input logic [5:0] funct,
                        input logic [31:0] rs, input logic [31:0] rt);
    bus.i_alu_op_CU  = op;
    bus.i_op_r_tipe  = funct;
    bus.i_rs_data    = rs;
    bus.i_rt_data    = rt;
    bus.i_forwardA   = 2'b00;
    bus.i_forwardB   = 2'b00;
    bus.i_alu_src_CU = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Arbitrary nonzero inputs while held in reset
    i_rst_n                  = 1'b0;
    bus.i_alu_src_CU         = 1'b0;
    bus.i_reg_dst_CU         = 1'b1;
    bus.i_jal_sel_CU         = 1'b0;
    bus.i_alu_op_CU          = 4'b0000;
    bus.i_rs_data            = 32'h1234;
    bus.i_rt_data            = 32'h0001;
    bus.i_rd_from_ID         = 5'd7;
    bus.i_rt_from_ID         = 5'd9;
    bus.i_inst_sign_extended = 32'h0;
    bus.i_aluResult_MEM      = 32'h0;
    bus.i_aluResult_WB       = 32'h0;
    bus.i_op_r_tipe          = 6'b100000;
    bus.i_forwardA           = 2'b00;
    bus.i_forwardB           = 2'b00;
    tick();
    check_all("reset1", 32'h0, 5'd0, 5'd0, 1'b0);
    tick();
    check_all("reset2", 32'h0, 5'd0, 5'd0, 1'b0);

    // ADD straight out of reset
    i_rst_n          = 1'b1;
    set_rr(4'b0000, 6'b000000, 32'h10, 32'h20);
    bus.i_reg_dst_CU = 1'b0;
    bus.i_rt_from_ID = 5'd2;
    bus.i_rd_from_ID = 5'd1;
    tick();
    check_all("add", 32'h30, 5'd2, 5'd1, 1'b0);

    bus.i_forwardA      = 2'b01;
    bus.i_aluResult_MEM = 32'h30;
    tick();
    check("fwdA_mem", bus.o_alu_result, 32'h50);

    bus.i_forwardB     = 2'b10;
    bus.i_aluResult_WB = 32'h40;
    tick();
    check("fwdB_wb", bus.o_alu_result, 32'h70);

    bus.i_alu_src_CU         = 1'b1;
    bus.i_inst_sign_extended = 32'h4;
    tick();
    check_all("imm", 32'h34, 5'd2, 5'd1, 1'b0);

    bus.i_jal_sel_CU = 1'b1;
    bus.i_reg_dst_CU = 1'b1;
    tick();
    check_all("jal", 32'h34, 5'd31, 5'd1, 1'b0);

    bus.i_jal_sel_CU = 1'b0;
    tick();
    check("regdst", {27'd0, bus.o_write_reg}, 32'd1);

    set_rr(4'b0010, 6'b100010, 32'h50, 32'h60);
    tick();
    check_all("rsub", 32'hFFFF_FFF0, 5'd1, 5'd1, 1'b0);

    bus.i_alu_op_CU     = 4'b0011;
    bus.i_forwardA      = 2'b01;
    bus.i_aluResult_MEM = 32'h70;
    bus.i_forwardB      = 2'b10;
    bus.i_aluResult_WB  = 32'h80;
    tick();
    check_all("and_zero", 32'h0, 5'd1, 5'd1, 1'b1);

    set_rr(4'b0010, 6'b000011, 32'h0, 32'h8000_0000);
    bus.i_inst_sign_extended = 32'h0000_0100;
    tick();
    check("sra", bus.o_alu_result, 32'hF800_0000);

    bus.i_op_r_tipe = 6'b000010;
    tick();
    check("srl", bus.o_alu_result, 32'h0800_0000);

    set_rr(4'b0010, 6'b000000, 32'h0, 32'h1);
    tick();
    check("sll", bus.o_alu_result, 32'h10);

    set_rr(4'b0010, 6'b000100, 32'h3, 32'h1);
    tick();
    check("sllv", bus.o_alu_result, 32'h8);

    set_rr(4'b0010, 6'b000111, 32'h24, 32'h8000_0000);
    tick();
    check("srav", bus.o_alu_result, 32'hF800_0000);

    set_rr(4'b0010, 6'b100111, 32'h0, 32'h0);
    tick();
    check_all("nor", 32'hFFFF_FFFF, 5'd1, 5'd1, 1'b0);

    // Select 11 must fall back to register data
    set_rr(4'b0101, 6'b0, 32'h0000_F0F0, 32'h0000_0FF0);
    bus.i_forwardA      = 2'b11;
    bus.i_forwardB      = 2'b11;
    bus.i_aluResult_MEM = 32'hDEAD_0000;
    tick();
    check("xor_fwd11", bus.o_alu_result, 32'h0000_FF00);

    set_rr(4'b0110, 6'b0, 32'h5, 32'h0);
    bus.i_alu_src_CU         = 1'b1;
    bus.i_inst_sign_extended = 32'h0000_1234;
    tick();
    check("lui", bus.o_alu_result, 32'h1234_0000);

    set_rr(4'b0111, 6'b0, 32'hFFFF_FFFF, 32'h1);
    tick();
    check("slt", bus.o_alu_result, 32'h1);

    bus.i_alu_op_CU = 4'b1000;
    tick();
    check_all("sltu", 32'h0, 5'd1, 5'd1, 1'b1);

    set_rr(4'b0001, 6'b0, 32'h0, 32'h1);
    tick();
    check("sub_wrap", bus.o_alu_result, 32'hFFFF_FFFF);

    set_rr(4'b1111, 6'b0, 32'hFFFF_FFFF, 32'h1);
    tick();
    check_all("undef_add_wrap", 32'h0, 5'd1, 5'd1, 1'b1);

    set_rr(4'b0100, 6'b0, 32'h0F00_0000, 32'h0000_00F0);
    bus.i_rd_from_ID = 5'd12;
    tick();
    check_all("or", 32'h0F00_00F0, 5'd12, 5'd12, 1'b0);

    // Reset has priority over live data
    i_rst_n = 1'b0;
    tick();
    check_all("reset3", 32'h0, 5'd0, 5'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
